ifetch: RTL and testbench



---
 rtl/ifetch_if.sv | 24 ++
 rtl/ifetch.sv | 116 +++++++++++
 tb/tb_ifetch.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface ifetch_if #(
  parameter int AW = 16,
  parameter int IW = 16
);
  logic          imem_req_out;
  logic [AW-1:0] imem_addr_out;
  logic          imem_ack_in;
  logic [IW-1:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in,
    output imem_rdata_in
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, IR and a single-entry prefetch buffer on a req/ack memory bus.
// Define MYCPU_IFETCH_BYPASS_EN to let an IR load take the memory word in its ack cycle.
module ifetch #(
  parameter int AW = 16,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ps_in,
  input  logic          il_in,
  input  logic [15:0]   ra_in,
  ifetch_if.master      imem,
  output logic [IW-1:0] ins_out,
  output logic [AW-1:0] pc_out,
  output logic          fetch_stall_out
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FULL
  } state_t;

  state_t        st;
  logic [AW-1:0] pc;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] br_off;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] ir;
  logic [IW-1:0] pf_buf;
  logic          stale;
  logic          pc_change;
  logic          ack_ok;
  logic          bypass;

  // Branch offset is the split 6-bit field {IR[8:6], IR[2:0]}, sign-extended.
  assign br_off = {{(AW-6){ir[8]}}, ir[8:6], ir[2:0]};

  always_comb begin
    next_pc = pc;
    case (ps_in)
      2'b00:   next_pc = pc;
      2'b01:   next_pc = pc + AW'(1);
      2'b10:   next_pc = pc + br_off;
      2'b11:   next_pc = AW'(ra_in);
      default: next_pc = pc;
    endcase
  end

  assign pc_change = (next_pc != pc);
  assign ack_ok    = (st == WAIT) && imem.imem_ack_in;

`ifdef MYCPU_IFETCH_BYPASS_EN
  assign bypass = il_in && ack_ok && !stale && !pc_change;
`else
  assign bypass = 1'b0;
`endif

  assign fetch_stall_out     = il_in && (st != FULL) && !bypass;
  assign imem.imem_req_out   = (st == WAIT);
  assign imem.imem_addr_out  = req_addr;
  assign ins_out             = ir;
  assign pc_out              = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      pc <= next_pc;
      // IR takes the old buffer even when the PC moves this cycle.
      if (il_in && (st == FULL)) begin
        ir <= pf_buf;
      end else if (bypass) begin
        ir <= imem.imem_rdata_in;
      end
    end
  end

  // A word requested for a PC that has since moved is dropped and refetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      stale    <= 1'b0;
      pf_buf   <= '0;
      req_addr <= '0;
    end else begin
      case (st)
        IDLE: begin
          req_addr <= next_pc;
          st       <= WAIT;
        end
        WAIT: begin
          if (ack_ok) begin
            if (stale || pc_change) begin
              stale <= 1'b0;
              st    <= IDLE;
            end else begin
              pf_buf <= imem.imem_rdata_in;
              st     <= FULL;
            end
          end else if (pc_change) begin
            stale <= 1'b1;
          end
        end
        FULL: begin
          if (pc_change) begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed testbench for ifetch: reset fetch, branch/wrap, stale discard, stall, bypass, reset mid-WAIT.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic [1:0]  ps_in;
  logic        il_in;
  logic [15:0] ra_in;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        fetch_stall_out;

  int tests_run;
  int tests_failed;

  ifetch_if #(.AW(16), .IW(16)) mem_bus ();

  ifetch #(.AW(16), .IW(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .ps_in           (ps_in),
    .il_in           (il_in),
    .ra_in           (ra_in),
    .imem            (mem_bus),
    .ins_out         (ins_out),
    .pc_out          (pc_out),
    .fetch_stall_out (fetch_stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ps, input logic il, input logic [15:0] ra,
                               input logic ack, input logic [15:0] rdata);
    ps_in                 = ps;
    il_in                 = il;
    ra_in                 = ra;
    mem_bus.imem_ack_in   = ack;
    mem_bus.imem_rdata_in = rdata;
    #1;
  endtask

  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    ps_in        = 2'b00;
    il_in        = 1'b0;
    ra_in        = 16'h0000;
    mem_bus.imem_ack_in   = 1'b0;
    mem_bus.imem_rdata_in = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req",   32'(mem_bus.imem_req_out),  32'h0);
    checkOutput("rst_addr",  32'(mem_bus.imem_addr_out), 32'h0);
    checkOutput("rst_ins",   32'(ins_out),               32'h0);
    checkOutput("rst_pc",    32'(pc_out),                32'h0);
    checkOutput("rst_stall", 32'(fetch_stall_out),       32'h0);

    // Reset fetch with a zero-wait memory
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("rf_req1",  32'(mem_bus.imem_req_out),  32'h1);
    checkOutput("rf_addr1", 32'(mem_bus.imem_addr_out), 32'h0000);
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h1234);
    stepClock();
    checkOutput("rf_req_drop", 32'(mem_bus.imem_req_out), 32'h0);
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b0, 16'h0000);
    checkOutput("rf_stall", 32'(fetch_stall_out), 32'h0);
    stepClock();
    checkOutput("rf_ins", 32'(ins_out), 32'h1234);

    // Walk PC to 2 and fetch IR = 0x01C7 (offset -1)
    applyStimulus(2'b01, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("inc_pc1", 32'(pc_out), 32'h0001);
    checkOutput("inc_req", 32'(mem_bus.imem_req_out), 32'h0);
    applyStimulus(2'b01, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("inc_pc2",  32'(pc_out), 32'h0002);
    checkOutput("inc_addr", 32'(mem_bus.imem_addr_out), 32'h0002);
    checkOutput("inc_req2", 32'(mem_bus.imem_req_out), 32'h1);
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h01C7);
    stepClock();
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("br_ir", 32'(ins_out), 32'h01C7);
    applyStimulus(2'b10, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("br_pc", 32'(pc_out), 32'h0001);

    // Jump to FFFF then increment wraps to 0000 while a request is pending
    applyStimulus(2'b11, 1'b0, 16'hFFFF, 1'b0, 16'h0000);
    stepClock();
    checkOutput("jmp_pc",   32'(pc_out), 32'hFFFF);
    checkOutput("jmp_addr", 32'(mem_bus.imem_addr_out), 32'hFFFF);
    applyStimulus(2'b01, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("wrap_pc",   32'(pc_out), 32'h0000);
    checkOutput("wrap_addr", 32'(mem_bus.imem_addr_out), 32'hFFFF);
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
    stepClock();
    checkOutput("wrap_discard_req", 32'(mem_bus.imem_req_out), 32'h0);

    // Stale discard: 3 wait states at 0x0010, jump to 0x0040 mid-WAIT
    applyStimulus(2'b11, 1'b0, 16'h0010, 1'b0, 16'h0000);
    stepClock();
    checkOutput("st_addr10", 32'(mem_bus.imem_addr_out), 32'h0010);
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    applyStimulus(2'b11, 1'b0, 16'h0040, 1'b0, 16'h0000);
    stepClock();
    checkOutput("st_pc40",   32'(pc_out), 32'h0040);
    checkOutput("st_hold",   32'(mem_bus.imem_addr_out), 32'h0010);
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b0, 16'h0000);
    checkOutput("stall_wait", 32'(fetch_stall_out), 32'h1);
    stepClock();
    checkOutput("stall_ir", 32'(ins_out), 32'h01C7);
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b1, 16'hAAAA);
    checkOutput("st_ack_stall", 32'(fetch_stall_out), 32'h1);
    stepClock();
    checkOutput("st_ir_kept", 32'(ins_out), 32'h01C7);
    checkOutput("st_req_off", 32'(mem_bus.imem_req_out), 32'h0);
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h5555);
    stepClock();
    checkOutput("st_req40",  32'(mem_bus.imem_req_out), 32'h1);
    checkOutput("st_addr40", 32'(mem_bus.imem_addr_out), 32'h0040);

    // Bypass: ack and IR load in the same cycle
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b1, 16'hBEEF);
`ifdef MYCPU_IFETCH_BYPASS_EN
    checkOutput("byp_stall", 32'(fetch_stall_out), 32'h0);
    stepClock();
    checkOutput("byp_ins", 32'(ins_out), 32'hBEEF);
`else
    checkOutput("byp_stall", 32'(fetch_stall_out), 32'h1);
    stepClock();
    checkOutput("byp_ins", 32'(ins_out), 32'h01C7);
`endif
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b0, 16'h0000);
    checkOutput("byp_full_stall", 32'(fetch_stall_out), 32'h0);
    stepClock();
    checkOutput("byp_ins2", 32'(ins_out), 32'hBEEF);

    // Reset asserted while a request is pending; late ack must be ignored
    applyStimulus(2'b01, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000);
    stepClock();
    checkOutput("mr_req_pre",  32'(mem_bus.imem_req_out),  32'h1);
    checkOutput("mr_addr_pre", 32'(mem_bus.imem_addr_out), 32'h0041);
    rst = 1'b1;
    #1;
    checkOutput("mr_req",   32'(mem_bus.imem_req_out),  32'h0);
    checkOutput("mr_addr",  32'(mem_bus.imem_addr_out), 32'h0);
    checkOutput("mr_pc",    32'(pc_out),                32'h0);
    checkOutput("mr_ins",   32'(ins_out),               32'h0);
    checkOutput("mr_stall", 32'(fetch_stall_out),       32'h0);
    stepClock();
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 16'h0000, 1'b1, 16'h9999);
    stepClock();
    checkOutput("mr_req_post", 32'(mem_bus.imem_req_out), 32'h1);
    checkOutput("mr_addr_post", 32'(mem_bus.imem_addr_out), 32'h0);
    applyStimulus(2'b00, 1'b1, 16'h0000, 1'b0, 16'h0000);
    checkOutput("mr_late_stall", 32'(fetch_stall_out), 32'h1);
    stepClock();
    checkOutput("mr_late_ins", 32'(ins_out), 32'h0);
    checkOutput("mr_late_req", 32'(mem_bus.imem_req_out), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
